// File: rtl/code_sequencer.sv
// Program store plus program counter with jump, halt/wrap and bounds-checked errors.
// Define CODE_SEQUENCER_PARITY_EN to store an even-parity bit per entry.
module code_sequencer #(
    parameter int CODE_WIDTH = 12,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 32,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     jump_line,
    input  logic                  is_write,
    input  logic [ADDR_W-1:0]     write_line,
    input  logic [CODE_WIDTH-1:0] write_data,
    output logic [CODE_WIDTH-1:0] code,
    output logic [ADDR_W-1:0]     code_index,
    output logic                  halted,
    output logic                  write_err,
    output logic                  jump_err,
    output logic                  parity_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

`ifdef CODE_SEQUENCER_PARITY_EN
    localparam int EW = CODE_WIDTH + 1;
`else
    localparam int EW = CODE_WIDTH;
`endif

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              jump_err_q, jump_err_d;
    logic              write_err_q, write_err_d;

    // Contents survive reset; only the power-up value is defined.
    logic [EW-1:0]     mem_q [DEPTH] = '{default: '0};

    logic              wr_ok;
    logic              jmp_ok;
    logic [EW-1:0]     wr_word;
    logic [EW-1:0]     rd_word;

    always_comb begin
        wr_ok  = is_write && (write_line < DEPTH_A);
        jmp_ok = jump_line < DEPTH_A;
`ifdef CODE_SEQUENCER_PARITY_EN
        wr_word = {^write_data, write_data};
`else
        wr_word = write_data;
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        jump_err_d  = 1'b0;
        write_err_d = is_write && !wr_ok;
        if (jump) begin
            if (jmp_ok) begin
                idx_d   = jump_line;
                state_d = RUN;
            end else begin
                jump_err_d = 1'b1;
            end
        end else if (active && state_q == RUN) begin
            if (idx_q == LAST_A) begin
                if (WRAP != 0) begin
                    idx_d = '0;
                end else begin
                    state_d = HALT;
                end
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            idx_q       <= '0;
            jump_err_q  <= 1'b0;
            write_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            jump_err_q  <= jump_err_d;
            write_err_q <= write_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[write_line[IDX_W-1:0]] <= wr_word;
        end
    end

    assign rd_word    = mem_q[idx_q[IDX_W-1:0]];
    assign code       = rd_word[CODE_WIDTH-1:0];
    assign code_index = idx_q;
    assign halted     = (state_q == HALT);
    assign write_err  = write_err_q;
    assign jump_err   = jump_err_q;

`ifdef CODE_SEQUENCER_PARITY_EN
    assign parity_err = rd_word[CODE_WIDTH] != ^rd_word[CODE_WIDTH-1:0];
`else
    assign parity_err = 1'b0;
`endif

endmodule
